// File: rtl/alu_rs_scheduler_pkg.sv
// Shared constants, entry record and CDB tag-lookup helper for the ALU reservation station.
// Optional same-cycle CDB forwarding into select is enabled by defining ALU_RS_CDB_FWD_EN.
`ifndef ALU_RS_SCHEDULER_PKG_SV
`define ALU_RS_SCHEDULER_PKG_SV
package alu_rs_scheduler_pkg;

    localparam int ROB_W           = 4;
    localparam int RS_SIZE_DEFAULT = 8;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef logic [ROB_W-1:0] rob_tag_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  precise;
        logic        more_precise;
        logic [31:0] imm;
        logic [31:0] pc;
        rob_tag_t    rob;
        logic        qj_busy;
        rob_tag_t    qj;
        logic [31:0] vj;
        logic        qk_busy;
        rob_tag_t    qk;
        logic [31:0] vk;
    } rs_entry_t;

    typedef struct packed {
        logic        valid;
        rob_tag_t    tag;
        logic [31:0] val;
    } cdb_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] val;
    } cdb_hit_t;

    // The LSB broadcast takes precedence when both buses carry the same tag.
    function automatic cdb_hit_t cdb_lookup(input rob_tag_t tag, input cdb_t alu, input cdb_t lsb);
        cdb_hit_t r;
        r.hit = 1'b0;
        r.val = 32'h0000_0000;
        if (lsb.valid && (lsb.tag == tag)) begin
            r.hit = 1'b1;
            r.val = lsb.val;
        end else if (alu.valid && (alu.tag == tag)) begin
            r.hit = 1'b1;
            r.val = alu.val;
        end else begin
            r.hit = 1'b0;
            r.val = 32'h0000_0000;
        end
        return r;
    endfunction

endpackage
`endif

// File: rtl/alu_rs_scheduler_if.sv
// Issue, CDB and ALU-request bundle of the ALU reservation station.
// master = decoder/CDB/ALU side, slave = reservation station.
interface alu_rs_scheduler_if;
    import alu_rs_scheduler_pkg::*;

    logic             in_config;
    logic [6:0]       in_opcode;
    logic [2:0]       in_precise;
    logic             in_more_precise;
    logic [31:0]      in_imm;
    logic [31:0]      in_PC;
    logic [ROB_W-1:0] in_rob_entry;
    logic             in_Qj_busy;
    logic [ROB_W-1:0] in_Qj;
    logic [31:0]      in_Vj;
    logic             in_Qk_busy;
    logic [ROB_W-1:0] in_Qk;
    logic [31:0]      in_Vk;

    logic             alu_cdb_config;
    logic [ROB_W-1:0] alu_cdb_rob_entry;
    logic [31:0]      alu_cdb_val;
    logic             lsb_cdb_config;
    logic [ROB_W-1:0] lsb_cdb_rob_entry;
    logic [31:0]      lsb_cdb_val;

    logic             out_full;
    logic             out_config;
    logic [31:0]      out_a;
    logic [31:0]      out_b;
    logic [31:0]      out_PC;
    logic [6:0]       out_opcode;
    logic [2:0]       out_precise;
    logic             out_more_precise;
    logic [31:0]      out_imm;
    logic [ROB_W-1:0] out_rob_entry;

    modport master (
        output in_config, in_opcode, in_precise, in_more_precise, in_imm, in_PC, in_rob_entry,
        output in_Qj_busy, in_Qj, in_Vj, in_Qk_busy, in_Qk, in_Vk,
        output alu_cdb_config, alu_cdb_rob_entry, alu_cdb_val,
        output lsb_cdb_config, lsb_cdb_rob_entry, lsb_cdb_val,
        input  out_full, out_config, out_a, out_b, out_PC, out_opcode, out_precise,
        input  out_more_precise, out_imm, out_rob_entry
    );

    modport slave (
        input  in_config, in_opcode, in_precise, in_more_precise, in_imm, in_PC, in_rob_entry,
        input  in_Qj_busy, in_Qj, in_Vj, in_Qk_busy, in_Qk, in_Vk,
        input  alu_cdb_config, alu_cdb_rob_entry, alu_cdb_val,
        input  lsb_cdb_config, lsb_cdb_rob_entry, lsb_cdb_val,
        output out_full, out_config, out_a, out_b, out_PC, out_opcode, out_precise,
        output out_more_precise, out_imm, out_rob_entry
    );
endinterface

// File: rtl/alu_rs_scheduler_rs_prio_select.sv
// Fixed-priority picker: reports whether any request is set and the lowest set index.
module rs_prio_select #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the last hit written is the lowest index.
    always_comb begin
        found = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: buffers decoded ops, snoops both CDBs, issues one ready op per cycle.
// Define ALU_RS_CDB_FWD_EN to let same-cycle CDB broadcasts make an entry selectable.
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback_config,
    alu_rs_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(RS_SIZE);

    rs_entry_t          entry_r [RS_SIZE];
    logic [RS_SIZE-1:0] valid_r;

    cdb_t               alu_cdb_s;
    cdb_t               lsb_cdb_s;
    cdb_hit_t           j_hit_s [RS_SIZE];
    cdb_hit_t           k_hit_s [RS_SIZE];
    cdb_hit_t           issue_j_s;
    cdb_hit_t           issue_k_s;
    rs_entry_t          issue_s;
    rs_entry_t          sel_entry_s;
    logic [31:0]        disp_a_s;
    logic [31:0]        disp_b_s;

    logic [RS_SIZE-1:0] ready_s;
    logic [RS_SIZE-1:0] free_s;
    logic               sel_found_s;
    logic [IDX_W-1:0]   sel_idx_s;
    logic               free_found_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic               full_s;

    logic               out_config_r;
    logic [31:0]        out_a_r;
    logic [31:0]        out_b_r;
    logic [31:0]        out_pc_r;
    logic [6:0]         out_opcode_r;
    logic [2:0]         out_precise_r;
    logic               out_more_precise_r;
    logic [31:0]        out_imm_r;
    rob_tag_t           out_rob_r;

    assign alu_cdb_s = {bus.alu_cdb_config, bus.alu_cdb_rob_entry, bus.alu_cdb_val};
    assign lsb_cdb_s = {bus.lsb_cdb_config, bus.lsb_cdb_rob_entry, bus.lsb_cdb_val};
    assign free_s    = ~valid_r;
    assign full_s    = &valid_r;

    // Per-entry CDB tag matches and the ready vector fed to select.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            j_hit_s[i] = cdb_lookup(entry_r[i].qj, alu_cdb_s, lsb_cdb_s);
            k_hit_s[i] = cdb_lookup(entry_r[i].qk, alu_cdb_s, lsb_cdb_s);
`ifdef ALU_RS_CDB_FWD_EN
            ready_s[i] = valid_r[i]
                       & (~entry_r[i].qj_busy | j_hit_s[i].hit)
                       & (~entry_r[i].qk_busy | k_hit_s[i].hit);
`else
            ready_s[i] = valid_r[i] & ~entry_r[i].qj_busy & ~entry_r[i].qk_busy;
`endif
        end
    end

    rs_prio_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_sel (
        .req   (ready_s),
        .found (sel_found_s),
        .idx   (sel_idx_s)
    );

    rs_prio_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free (
        .req   (free_s),
        .found (free_found_s),
        .idx   (free_idx_s)
    );

    // New entry image, including wakeup from a broadcast in the issue cycle itself.
    always_comb begin
        issue_j_s            = cdb_lookup(bus.in_Qj, alu_cdb_s, lsb_cdb_s);
        issue_k_s            = cdb_lookup(bus.in_Qk, alu_cdb_s, lsb_cdb_s);
        issue_s.opcode       = bus.in_opcode;
        issue_s.precise      = bus.in_precise;
        issue_s.more_precise = bus.in_more_precise;
        issue_s.imm          = bus.in_imm;
        issue_s.pc           = bus.in_PC;
        issue_s.rob          = bus.in_rob_entry;
        issue_s.qj           = bus.in_Qj;
        issue_s.qk           = bus.in_Qk;
        if (bus.in_Qj_busy && issue_j_s.hit) begin
            issue_s.qj_busy = 1'b0;
            issue_s.vj      = issue_j_s.val;
        end else begin
            issue_s.qj_busy = bus.in_Qj_busy;
            issue_s.vj      = bus.in_Vj;
        end
        if (bus.in_Qk_busy && issue_k_s.hit) begin
            issue_s.qk_busy = 1'b0;
            issue_s.vk      = issue_k_s.val;
        end else begin
            issue_s.qk_busy = bus.in_Qk_busy;
            issue_s.vk      = bus.in_Vk;
        end
    end

    // Operands of the selected entry; with forwarding a still-busy operand comes off the CDB.
    always_comb begin
        sel_entry_s = entry_r[sel_idx_s];
`ifdef ALU_RS_CDB_FWD_EN
        if (sel_entry_s.qj_busy) begin
            disp_a_s = j_hit_s[sel_idx_s].val;
        end else begin
            disp_a_s = sel_entry_s.vj;
        end
        if (sel_entry_s.qk_busy) begin
            disp_b_s = k_hit_s[sel_idx_s].val;
        end else begin
            disp_b_s = sel_entry_s.vk;
        end
`else
        disp_a_s = sel_entry_s.vj;
        disp_b_s = sel_entry_s.vk;
`endif
    end

    // Entry storage: CDB wakeup, release on dispatch, write on issue; rollback drops all validity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {RS_SIZE{1'b0}};
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_r[i] <= '0;
            end
        end else if (rdy) begin
            if (rollback_config) begin
                valid_r <= {RS_SIZE{1'b0}};
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (valid_r[i] && entry_r[i].qj_busy && j_hit_s[i].hit) begin
                        entry_r[i].qj_busy <= 1'b0;
                        entry_r[i].vj      <= j_hit_s[i].val;
                    end
                    if (valid_r[i] && entry_r[i].qk_busy && k_hit_s[i].hit) begin
                        entry_r[i].qk_busy <= 1'b0;
                        entry_r[i].vk      <= k_hit_s[i].val;
                    end
                end
                if (sel_found_s) begin
                    valid_r[sel_idx_s] <= 1'b0;
                end
                // The free slot is never the dispatched one, so both updates can coexist.
                if (bus.in_config && free_found_s) begin
                    entry_r[free_idx_s] <= issue_s;
                    valid_r[free_idx_s] <= 1'b1;
                end
            end
        end
    end

    // Registered ALU request; payload holds when nothing is dispatched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_config_r       <= 1'b0;
            out_a_r            <= 32'h0000_0000;
            out_b_r            <= 32'h0000_0000;
            out_pc_r           <= 32'h0000_0000;
            out_opcode_r       <= 7'b0000000;
            out_precise_r      <= 3'b000;
            out_more_precise_r <= 1'b0;
            out_imm_r          <= 32'h0000_0000;
            out_rob_r          <= {ROB_W{1'b0}};
        end else if (rdy) begin
            if (rollback_config) begin
                out_config_r <= 1'b0;
            end else if (sel_found_s) begin
                out_config_r       <= 1'b1;
                out_a_r            <= disp_a_s;
                out_b_r            <= disp_b_s;
                out_pc_r           <= sel_entry_s.pc;
                out_opcode_r       <= sel_entry_s.opcode;
                out_precise_r      <= sel_entry_s.precise;
                out_more_precise_r <= sel_entry_s.more_precise;
                out_imm_r          <= sel_entry_s.imm;
                out_rob_r          <= sel_entry_s.rob;
            end else begin
                out_config_r <= 1'b0;
            end
        end
    end

    assign bus.out_full         = full_s;
    assign bus.out_config       = out_config_r;
    assign bus.out_a            = out_a_r;
    assign bus.out_b            = out_b_r;
    assign bus.out_PC           = out_pc_r;
    assign bus.out_opcode       = out_opcode_r;
    assign bus.out_precise      = out_precise_r;
    assign bus.out_more_precise = out_more_precise_r;
    assign bus.out_imm          = out_imm_r;
    assign bus.out_rob_entry    = out_rob_r;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Self-checking bench for alu_rs_scheduler: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a behavioural reservation-station model.
module tb_alu_rs_scheduler;
    import alu_rs_scheduler_pkg::*;

    localparam int RS = 8;
`ifdef ALU_RS_CDB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic rollback = 1'b0;

    alu_rs_scheduler_if bus();

    alu_rs_scheduler #(.RS_SIZE(RS)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .rollback_config (rollback),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [6:0]  op;
        logic [2:0]  pr;
        logic        mp;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
        bit          jb;
        logic [3:0]  qj;
        logic [31:0] vj;
        bit          kb;
        logic [3:0]  qk;
        logic [31:0] vk;
    } ment_t;

    ment_t m [RS];
    ment_t pre [RS];
    bit          e_cfg = 1'b0;
    logic [31:0] e_a = 32'd0, e_b = 32'd0, e_pc = 32'd0, e_imm = 32'd0;
    logic [6:0]  e_op = 7'd0;
    logic [2:0]  e_pr = 3'd0;
    logic        e_mp = 1'b0;
    logic [3:0]  e_rob = 4'd0;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk(nm, {112'd0, act}, {112'd0, exp});
    endtask

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < RS; i++) if (m[i].v) c++;
        return c;
    endfunction

    // Value carried for tag t by the CDBs this cycle, LSB first.
    function automatic bit bcdb(input logic [3:0] t, output logic [31:0] v);
        v = 32'd0;
        if (bus.lsb_cdb_config && bus.lsb_cdb_rob_entry == t) begin
            v = bus.lsb_cdb_val;
            return 1'b1;
        end
        if (bus.alu_cdb_config && bus.alu_cdb_rob_entry == t) begin
            v = bus.alu_cdb_val;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS; i++) m[i] = '{default: 0};
        e_cfg = 1'b0; e_a = 32'd0; e_b = 32'd0; e_pc = 32'd0; e_imm = 32'd0;
        e_op = 7'd0; e_pr = 3'd0; e_mp = 1'b0; e_rob = 4'd0;
    endtask

    task automatic model_step();
        int sel;
        int fr;
        int cnt;
        bit okj;
        bit okk;
        logic [31:0] v;
        logic [31:0] v2;
        pre = m;
        cnt = mcount();
        if (rollback) begin
            for (int i = 0; i < RS; i++) m[i].v = 1'b0;
            e_cfg = 1'b0;
            return;
        end
        sel = -1;
        for (int i = 0; i < RS; i++) begin
            if (sel < 0 && pre[i].v) begin
                okj = !pre[i].jb || (FWD && bcdb(pre[i].qj, v));
                okk = !pre[i].kb || (FWD && bcdb(pre[i].qk, v));
                if (okj && okk) sel = i;
            end
        end
        if (sel >= 0) begin
            e_cfg = 1'b1;
            e_a = pre[sel].vj;
            if (pre[sel].jb && bcdb(pre[sel].qj, v)) e_a = v;
            e_b = pre[sel].vk;
            if (pre[sel].kb && bcdb(pre[sel].qk, v)) e_b = v;
            e_pc = pre[sel].pc; e_op = pre[sel].op; e_pr = pre[sel].pr;
            e_mp = pre[sel].mp; e_imm = pre[sel].imm; e_rob = pre[sel].rob;
            m[sel].v = 1'b0;
        end else begin
            e_cfg = 1'b0;
        end
        for (int i = 0; i < RS; i++) begin
            if (pre[i].v && pre[i].jb && bcdb(pre[i].qj, v)) begin m[i].jb = 1'b0; m[i].vj = v; end
            if (pre[i].v && pre[i].kb && bcdb(pre[i].qk, v)) begin m[i].kb = 1'b0; m[i].vk = v; end
        end
        if (bus.in_config && cnt < RS) begin
            fr = -1;
            for (int i = 0; i < RS; i++) if (fr < 0 && !pre[i].v) fr = i;
            m[fr].v = 1'b1; m[fr].op = bus.in_opcode; m[fr].pr = bus.in_precise;
            m[fr].mp = bus.in_more_precise; m[fr].imm = bus.in_imm; m[fr].pc = bus.in_PC;
            m[fr].rob = bus.in_rob_entry;
            m[fr].qj = bus.in_Qj; m[fr].jb = bus.in_Qj_busy; m[fr].vj = bus.in_Vj;
            if (bus.in_Qj_busy && bcdb(bus.in_Qj, v2)) begin m[fr].jb = 1'b0; m[fr].vj = v2; end
            m[fr].qk = bus.in_Qk; m[fr].kb = bus.in_Qk_busy; m[fr].vk = bus.in_Vk;
            if (bus.in_Qk_busy && bcdb(bus.in_Qk, v2)) begin m[fr].kb = 1'b0; m[fr].vk = v2; end
        end
    endtask

    // Inputs only change on the falling edge, so just after the rising edge they still show what the edge saw.
    always begin
        @(posedge clk);
        #1;
        if (!rst) model_reset();
        else if (rdy) model_step();
        chk("out_full", {143'd0, bus.out_full}, {143'd0, (mcount() == RS)});
        chk("out_bus",
            {bus.out_config, bus.out_a, bus.out_b, bus.out_PC, bus.out_opcode, bus.out_precise,
             bus.out_more_precise, bus.out_imm, bus.out_rob_entry},
            {e_cfg, e_a, e_b, e_pc, e_op, e_pr, e_mp, e_imm, e_rob});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_config = 1'b0;
        bus.alu_cdb_config = 1'b0;
        bus.lsb_cdb_config = 1'b0;
        rollback = 1'b0;
        rdy = 1'b1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [31:0] imm, input logic [3:0] rob,
                         input logic jb, input logic [3:0] qj, input logic [31:0] vj,
                         input logic kb, input logic [3:0] qk, input logic [31:0] vk);
        bus.in_config = 1'b1; bus.in_opcode = op; bus.in_precise = 3'd0; bus.in_more_precise = 1'b0;
        bus.in_imm = imm; bus.in_PC = 32'h0000_1000 + {26'd0, rob, 2'b00}; bus.in_rob_entry = rob;
        bus.in_Qj_busy = jb; bus.in_Qj = qj; bus.in_Vj = vj;
        bus.in_Qk_busy = kb; bus.in_Qk = qk; bus.in_Vk = vk;
    endtask

    initial begin
        int start_i;
        logic [6:0] ops [5];
        ops[0] = OP_IMM; ops[1] = OP; ops[2] = BRANCH; ops[3] = JAL; ops[4] = AUIPC;
        idle();
        issue(OP_IMM, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        bus.in_config = 1'b0;
        bus.alu_cdb_rob_entry = 4'd0; bus.alu_cdb_val = 32'd0;
        bus.lsb_cdb_rob_entry = 4'd0; bus.lsb_cdb_val = 32'd0;
        repeat (2) tick();
        chk32("reset_cfg", {31'd0, bus.out_config}, 32'd0);
        chk32("reset_full", {31'd0, bus.out_full}, 32'd0);
        chk32("reset_a", bus.out_a, 32'd0);
        nedge(); rst = 1'b1;
        tick();

        // ADDI with ready operand: request one edge after issue.
        nedge(); issue(OP_IMM, 32'd3, 4'd2, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0);
        tick(); chk32("addi_no_same_edge", {31'd0, bus.out_config}, 32'd0);
        nedge(); idle();
        tick();
        chk32("addi_cfg", {31'd0, bus.out_config}, 32'd1);
        chk32("addi_a", bus.out_a, 32'd5);
        chk32("addi_imm", bus.out_imm, 32'd3);
        chk32("addi_rob", {28'd0, bus.out_rob_entry}, 32'd2);
        nedge(); tick(); chk32("addi_freed", {31'd0, bus.out_config}, 32'd0);

        // ADD waiting on tag 7, woken by the ALU CDB two cycles after issue.
        nedge(); issue(OP, 32'd0, 4'd3, 1'b1, 4'd7, 32'hDEAD_0000, 1'b0, 4'd0, 32'd1);
        tick();
        nedge(); idle(); tick();
        chk32("add_wait", {31'd0, bus.out_config}, 32'd0);
        nedge(); bus.alu_cdb_config = 1'b1; bus.alu_cdb_rob_entry = 4'd7; bus.alu_cdb_val = 32'h10;
        tick();
`ifndef ALU_RS_CDB_FWD_EN
        chk32("add_wake_cfg0", {31'd0, bus.out_config}, 32'd0);
        nedge(); idle(); tick();
`endif
        chk32("add_cfg", {31'd0, bus.out_config}, 32'd1);
        chk32("add_a", bus.out_a, 32'h10);
        chk32("add_rob", {28'd0, bus.out_rob_entry}, 32'd3);
        nedge(); idle(); tick();

        // Fill all entries waiting on tag 3, release with one LSB broadcast.
        for (int i = 0; i < RS; i++) begin
            nedge(); issue(OP, 32'd0, 4'(i), 1'b1, 4'd3, 32'hBAD, 1'b0, 4'd0, 32'(i));
            tick();
        end
        chk32("fill_full", {31'd0, bus.out_full}, 32'd1);
        nedge(); idle(); bus.lsb_cdb_config = 1'b1; bus.lsb_cdb_rob_entry = 4'd3; bus.lsb_cdb_val = 32'h33;
        tick();
`ifdef ALU_RS_CDB_FWD_EN
        chk32("drain_rob", {28'd0, bus.out_rob_entry}, 32'd0);
        chk32("drain_full", {31'd0, bus.out_full}, 32'd0);
        start_i = 1;
`else
        chk32("drain_wake_cfg0", {31'd0, bus.out_config}, 32'd0);
        start_i = 0;
`endif
        for (int i = start_i; i < RS; i++) begin
            nedge(); idle(); tick();
            chk32("drain_cfg", {31'd0, bus.out_config}, 32'd1);
            chk32("drain_rob", {28'd0, bus.out_rob_entry}, 32'(i));
            chk32("drain_a", bus.out_a, 32'h33);
            chk32("drain_full", {31'd0, bus.out_full}, 32'd0);
        end
        nedge(); idle(); tick();

        // Issue-time wakeup of Qk from the LSB CDB.
        nedge(); issue(OP, 32'd0, 4'd4, 1'b0, 4'd0, 32'd1, 1'b1, 4'd5, 32'd0);
        bus.lsb_cdb_config = 1'b1; bus.lsb_cdb_rob_entry = 4'd5; bus.lsb_cdb_val = 32'hAB;
        tick(); chk32("iwake_no_same_edge", {31'd0, bus.out_config}, 32'd0);
        nedge(); idle(); tick();
        chk32("iwake_cfg", {31'd0, bus.out_config}, 32'd1);
        chk32("iwake_b", bus.out_b, 32'hAB);
        nedge(); idle(); tick();

        // Rollback beats a concurrent issue.
        nedge(); issue(OP, 32'd0, 4'd5, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd0); tick();
        nedge(); issue(OP, 32'd0, 4'd6, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd0); tick();
        nedge(); issue(OP_IMM, 32'd1, 4'd7, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0); rollback = 1'b1;
        tick();
        chk32("rb_cfg", {31'd0, bus.out_config}, 32'd0);
        chk32("rb_full", {31'd0, bus.out_full}, 32'd0);
        nedge(); idle(); bus.alu_cdb_config = 1'b1; bus.alu_cdb_rob_entry = 4'd9; bus.alu_cdb_val = 32'd9;
        tick(); chk32("rb_discard0", {31'd0, bus.out_config}, 32'd0);
        nedge(); idle(); tick(); chk32("rb_discard1", {31'd0, bus.out_config}, 32'd0);

        // rdy low freezes a pending request and a ready entry, even against rollback.
        nedge(); issue(OP_IMM, 32'd0, 4'd10, 1'b0, 4'd0, 32'h100, 1'b0, 4'd0, 32'd0); tick();
        nedge(); issue(OP_IMM, 32'd0, 4'd11, 1'b0, 4'd0, 32'h200, 1'b0, 4'd0, 32'd0); tick();
        chk32("rdy_first", {28'd0, bus.out_rob_entry}, 32'd10);
        nedge(); idle(); rdy = 1'b0; rollback = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk32("rdy_hold_cfg", {31'd0, bus.out_config}, 32'd1);
            chk32("rdy_hold_rob", {28'd0, bus.out_rob_entry}, 32'd10);
        end
        nedge(); idle(); tick();
        chk32("rdy_resume_rob", {28'd0, bus.out_rob_entry}, 32'd11);
        chk32("rdy_resume_a", bus.out_a, 32'h200);
        nedge(); idle(); tick(); chk32("rdy_done", {31'd0, bus.out_config}, 32'd0);

        // Asynchronous reset in the middle of a cycle clears outputs immediately.
        nedge(); issue(OP_IMM, 32'd0, 4'd12, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'd0); tick();
        nedge(); issue(OP, 32'd0, 4'd13, 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'd0); tick();
        chk32("arst_pre", {31'd0, bus.out_config}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk32("arst_cfg", {31'd0, bus.out_config}, 32'd0);
        chk32("arst_a", bus.out_a, 32'd0);
        nedge(); idle(); tick();
        nedge(); rst = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            nedge();
            rdy = ($urandom_range(0, 7) != 0);
            rollback = ($urandom_range(0, 63) == 0);
            bus.alu_cdb_config = 1'($urandom_range(0, 1));
            bus.alu_cdb_rob_entry = 4'($urandom_range(0, 3));
            bus.alu_cdb_val = $urandom;
            bus.lsb_cdb_config = 1'($urandom_range(0, 1));
            bus.lsb_cdb_rob_entry = 4'($urandom_range(0, 3));
            bus.lsb_cdb_val = $urandom;
            if (mcount() < RS && $urandom_range(0, 2) != 0) begin
                issue(ops[$urandom_range(0, 4)], $urandom, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom,
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom);
                bus.in_precise = 3'($urandom_range(0, 7));
                bus.in_more_precise = 1'($urandom_range(0, 1));
            end else begin
                bus.in_config = 1'b0;
            end
            if (bus.in_config && bus.out_full) $error("decoder protocol broken: issue while out_full");
        end
        nedge(); idle();
        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
